// File: rtl/apb_regfile_pkg.sv
// Shared types and helpers for the APB register-file completer.
// Optional feature macro used by the top level: APB_REGFILE_PSTRB_EN.
package apb_regfile_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  localparam int WAIT_CNT_WIDTH = 4;

  // Byte-address bits below the word index for a given data width.
  function automatic int addr_lsb(input int data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/apb_access_fsm.sv
// APB access-phase sequencer: state register, wait-state down-counter
// and PREADY generation.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | no transfer; a setup phase (PSEL=1, PENABLE=0) starts one
//   ACCESS | setup seen; count wait states, then PREADY completes it
module apb_access_fsm
  import apb_regfile_pkg::*;
#(
  parameter int WAIT_STATES = 0
) (
  input  logic pclk,
  input  logic presetn,
  input  logic psel,
  input  logic penable,
  output logic pready
);

  localparam logic [WAIT_CNT_WIDTH-1:0] WAIT_LOAD = WAIT_CNT_WIDTH'(WAIT_STATES);

  state_e                    state_q, state_d;
  logic [WAIT_CNT_WIDTH-1:0] wait_cnt_q, wait_cnt_d;

  // State and wait counter registers.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Next state, wait count and PREADY; PREADY is purely combinational.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    pready     = 1'b0;
    case (state_q)
      IDLE: begin
        if (psel && !penable) begin
          state_d    = ACCESS;
          wait_cnt_d = WAIT_LOAD;
        end
      end
      ACCESS: begin
        if (!psel) begin
          // requester abandoned the transfer
          state_d = IDLE;
        end else if (penable) begin
          if (wait_cnt_q != '0) begin
            wait_cnt_d = wait_cnt_q - 1'b1;
          end else begin
            pready  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: rtl/apb_regfile_completer.sv
// APB completer with a bank of read/write registers, programmable wait
// states and PSLVERR on misaligned or out-of-range addresses.
// Optional byte-lane strobes: define APB_REGFILE_PSTRB_EN to add PSTRB.
module apb_regfile_completer
  import apb_regfile_pkg::*;
#(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_REGS    = 4,
  parameter int WAIT_STATES = 0
) (
  input  logic                           PCLK,
  input  logic                           PRESETn,
  input  logic                           PSEL,
  input  logic                           PENABLE,
  input  logic                           PWRITE,
  input  logic [ADDR_WIDTH-1:0]          PADDR,
  input  logic [DATA_WIDTH-1:0]          PWDATA,
`ifdef APB_REGFILE_PSTRB_EN
  input  logic [DATA_WIDTH/8-1:0]        PSTRB,
`endif
  output logic [DATA_WIDTH-1:0]          PRDATA,
  output logic                           PREADY,
  output logic                           PSLVERR,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q
);

  localparam int                    NUM_LANES = DATA_WIDTH / 8;
  localparam int                    ADDR_LSB  = addr_lsb(DATA_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] LSB_MASK  = ADDR_WIDTH'((1 << ADDR_LSB) - 1);

  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_q, regs_d;
  logic [ADDR_WIDTH-1:0]               index;
  logic                                addr_err;
  logic                                wr_en;
  logic [NUM_LANES-1:0]                wstrb;
  logic [DATA_WIDTH-1:0]               rdata;

  apb_access_fsm #(
    .WAIT_STATES (WAIT_STATES)
  ) u_fsm (
    .pclk    (PCLK),
    .presetn (PRESETn),
    .psel    (PSEL),
    .penable (PENABLE),
    .pready  (PREADY)
  );

  assign index    = PADDR >> ADDR_LSB;
  assign addr_err = ((PADDR & LSB_MASK) != '0) || (int'(index) >= NUM_REGS);
  assign wr_en    = PREADY && PWRITE && !addr_err;

`ifdef APB_REGFILE_PSTRB_EN
  assign wstrb = PSTRB;
`else
  assign wstrb = '1;
`endif

  // Register bank; cleared asynchronously so a write in flight is lost.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      regs_q <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // Byte-lane merge of write data into the addressed register.
  always_comb begin
    regs_d = regs_q;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (wr_en && (int'(index) == i)) begin
        for (int b = 0; b < NUM_LANES; b++) begin
          if (wstrb[b]) begin
            regs_d[i][b*8 +: 8] = PWDATA[b*8 +: 8];
          end
        end
      end
    end
  end

  // Read mux over the register bank.
  always_comb begin
    rdata = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (int'(index) == i) begin
        rdata = regs_q[i];
      end
    end
  end

  assign PRDATA  = (PREADY && !PWRITE && !addr_err) ? rdata : '0;
  assign PSLVERR = PREADY && addr_err;
  assign reg_q   = regs_q;

endmodule

// File: tb/tb_apb_regfile_completer.sv
// Bench for apb_regfile_completer: a zero-wait and a three-wait instance
// side by side on a shared bus with separate selects and resets.
// Honours APB_REGFILE_PSTRB_EN for the strobe steps.
module tb_apb_regfile_completer;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int NR = 4;
  localparam int NB = DW / 8;
`ifdef APB_REGFILE_PSTRB_EN
  localparam bit STRB_EN = 1'b1;
`else
  localparam bit STRB_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst0, rst1;
  logic [1:0]    psel;
  logic          penable, pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic [NB-1:0] pstrb;

  logic [DW-1:0]    prdata0, prdata1;
  logic             pready0, pready1, pslverr0, pslverr1;
  logic [NR*DW-1:0] regq0, regq1;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] model [2][NR];

  apb_regfile_completer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR), .WAIT_STATES(0)) dut0 (
    .PCLK(clk), .PRESETn(rst0), .PSEL(psel[0]), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata),
`ifdef APB_REGFILE_PSTRB_EN
    .PSTRB(pstrb),
`endif
    .PRDATA(prdata0), .PREADY(pready0), .PSLVERR(pslverr0), .reg_q(regq0)
  );

  apb_regfile_completer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR), .WAIT_STATES(3)) dut1 (
    .PCLK(clk), .PRESETn(rst1), .PSEL(psel[1]), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata),
`ifdef APB_REGFILE_PSTRB_EN
    .PSTRB(pstrb),
`endif
    .PRDATA(prdata1), .PREADY(pready1), .PSLVERR(pslverr1), .reg_q(regq1)
  );

  task automatic chk(input string tag, input logic [NR*DW-1:0] obs, input logic [NR*DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NR*DW-1:0] model_flat(input int d);
    logic [NR*DW-1:0] f;
    for (int i = 0; i < NR; i++) f[i*DW +: DW] = model[d][i];
    return f;
  endfunction

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] wd,
                                          input logic [NB-1:0] st);
    logic [DW-1:0] r;
    r = old;
    for (int b = 0; b < NB; b++)
      if (!STRB_EN || st[b]) r[b*8 +: 8] = wd[b*8 +: 8];
    return r;
  endfunction

  task automatic clear_model(input int d);
    for (int i = 0; i < NR; i++) model[d][i] = '0;
  endtask

  task automatic check_banks(input string tag);
    chk({tag, "_regq0"}, regq0, model_flat(0));
    chk({tag, "_regq1"}, regq1, model_flat(1));
  endtask

  // Entered and left at 1 time unit after a rising edge, so calls chain
  // back-to-back with no idle cycle in between.
  task automatic xfer(input int d, input bit wr, input logic [AW-1:0] a,
                      input logic [DW-1:0] wd, input logic [NB-1:0] st, input string tag);
    int            ws;
    int            idx;
    bit            err;
    logic [DW-1:0] exp_rd;
    ws  = (d == 0) ? 0 : 3;
    err = (int'(a) % NB != 0) || (int'(a) / NB >= NR);
    idx = err ? 0 : int'(a) / NB;
    exp_rd = (!wr && !err) ? model[d][idx] : '0;
    psel    = '0;
    psel[d] = 1'b1;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = a;
    pwdata  = wd;
    pstrb   = st;
    @(posedge clk); #1;
    penable = 1'b1;
    for (int k = 1; k <= ws + 1; k++) begin
      #1;
      chk({tag, "_pready"}, (d == 0) ? pready0 : pready1, (k == ws + 1) ? 1'b1 : 1'b0);
      chk({tag, "_prdata"}, (d == 0) ? prdata0 : prdata1, (k == ws + 1) ? exp_rd : '0);
      if (k == ws + 1) begin
        chk({tag, "_pslverr"}, (d == 0) ? pslverr0 : pslverr1, err);
      end else begin
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;
    if (wr && !err) model[d][idx] = merge(model[d][idx], wd, st);
    psel    = '0;
    penable = 1'b0;
    check_banks(tag);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst0 = 1'b0; rst1 = 1'b0;
    psel = '0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '1;
    clear_model(0);
    clear_model(1);

    // reset state
    repeat (2) @(posedge clk);
    #2;
    chk("rst_pready0", pready0, 1'b0);
    chk("rst_pready1", pready1, 1'b0);
    chk("rst_pslverr0", pslverr0, 1'b0);
    chk("rst_prdata0", prdata0, '0);
    chk("rst_prdata1", prdata1, '0);
    check_banks("rst");
    rst0 = 1'b1; rst1 = 1'b1;
    idle(1);

    // basic write, then the same data on the wait-state instance and read it
    xfer(0, 1'b1, 8'h04, 32'hDEADBEEF, '1, "wr04_ws0");
    chk("wr04_word1", regq0[63:32], 32'hDEADBEEF);
    xfer(1, 1'b1, 8'h04, 32'hDEADBEEF, '1, "wr04_ws3");
    xfer(1, 1'b0, 8'h04, '0, '1, "rd04_ws3");

    // error responses
    xfer(0, 1'b1, 8'h10, 32'h12345678, '1, "wr_oor");
    xfer(0, 1'b1, 8'h02, 32'h12345678, '1, "wr_mis");
    xfer(0, 1'b0, 8'h10, '0, '1, "rd_oor");
    xfer(0, 1'b0, 8'h03, '0, '1, "rd_mis");
    xfer(1, 1'b1, 8'h11, 32'h0BADF00D, '1, "wr_err_ws3");
    xfer(1, 1'b0, 8'hFC, '0, '1, "rd_err_ws3");

    // back-to-back write then read, no idle cycle
    xfer(0, 1'b1, 8'h00, 32'h11111111, '1, "b2b_wr0");
    xfer(0, 1'b0, 8'h00, '0, '1, "b2b_rd0");
    xfer(1, 1'b1, 8'h00, 32'h11111111, '1, "b2b_wr1");
    xfer(1, 1'b0, 8'h00, '0, '1, "b2b_rd1");

    if (STRB_EN) begin
      xfer(0, 1'b1, 8'h00, 32'hAABBCCDD, 4'b0101, "strb_wr");
      chk("strb_word0", regq0[31:0], 32'h11BB11DD);
      xfer(0, 1'b1, 8'h00, 32'hFFFFFFFF, 4'b0000, "strb_zero");
      xfer(0, 1'b0, 8'h00, '0, 4'b0000, "strb_rd");
    end

    // abort: PSEL drops during the access phase
    psel = 2'b10; penable = 1'b0; pwrite = 1'b1; paddr = 8'h08; pwdata = 32'h5A5A5A5A;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    psel = '0;
    #1;
    chk("abort_pready", pready1, 1'b0);
    idle(5);
    check_banks("abort");

    // randomized traffic
    for (int n = 0; n < 80; n++) begin
      xfer(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), AW'($urandom_range(0, 19)),
           $urandom, NB'($urandom), "rnd");
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
    end

    // reset in the middle of a wait state of a write
    psel = 2'b10; penable = 1'b0; pwrite = 1'b1; paddr = 8'h08; pwdata = 32'hCAFEF00D; pstrb = '1;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    rst1 = 1'b0;
    clear_model(1);
    #1;
    chk("midrst_pready", pready1, 1'b0);
    chk("midrst_prdata", prdata1, '0);
    chk("midrst_regq1", regq1, '0);
    idle(2);
    rst1 = 1'b1;
    // PENABLE still high while in IDLE must not start anything
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("idle_penable_pready", pready1, 1'b0);
      @(posedge clk); #1;
    end
    psel = '0; penable = 1'b0;
    check_banks("post_rst");
    xfer(1, 1'b1, 8'h0C, 32'h600DCAFE, '1, "post_rst_wr");
    xfer(1, 1'b0, 8'h0C, '0, '1, "post_rst_rd");
    xfer(1, 1'b0, 8'h08, '0, '1, "post_rst_rd08");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/apb_regfile_completer.md
# apb_regfile_completer

Parametrised APB completer holding a bank of read/write registers, with programmable wait states and error response. It supersedes the minimal PSEL/PENABLE-only dummy completer: it adds full address/data/write decoding, PREADY/PSLVERR generation, and width, depth and latency parameters. It sits behind an APB interconnect port and exports register contents to downstream logic. It is built so that two configurations can be placed side by side in the equivalence bench.

## Interface
- ADDR_WIDTH, 8, PADDR width in bits; must satisfy 2^ADDR_WIDTH >= NUM_REGS*DATA_WIDTH/8.
- DATA_WIDTH, 32, PWDATA/PRDATA width; legal values are 8, 16 and 32.
- NUM_REGS, 4, number of registers; legal range 1..256.
- WAIT_STATES, 0, cycles PREADY is held low in the access phase; legal range 0..15.
- PCLK  input  1  APB clock; all state changes on its rising edge.
- PRESETn  input  1  asynchronous, active-low reset.
- PSEL  input  1  completer select.
- PENABLE  input  1  access phase indicator.
- PWRITE  input  1  1 = write, 0 = read.
- PADDR  input  ADDR_WIDTH  byte address.
- PWDATA  input  DATA_WIDTH  write data.
- PSTRB  input  DATA_WIDTH/8  byte-lane write strobes; present only with APB_REGFILE_PSTRB_EN.
- PRDATA  output  DATA_WIDTH  read data.
- PREADY  output  1  transfer completion.
- PSLVERR  output  1  error response; valid only when PREADY=1.
- reg_q  output  NUM_REGS*DATA_WIDTH  all register contents, register i at bits [i*DATA_WIDTH +: DATA_WIDTH].

## Operation
- Reset values: every register is 0, state is IDLE, and PREADY, PSLVERR and PRDATA are all 0.
- FSM states:
  - IDLE: on PSEL=1 and PENABLE=0, go to ACCESS and load wait_cnt with WAIT_STATES.
  - ACCESS, with PSEL=1 and PENABLE=1:
    - wait_cnt != 0: decrement wait_cnt.
    - wait_cnt == 0: PREADY=1 and the transfer completes on that edge; go to IDLE.
  - ACCESS, with PSEL=0: abort. Return to IDLE, no register update, PREADY stays 0.
- Address decode:
  - ADDR_LSB = log2(DATA_WIDTH/8).
  - index = PADDR >> ADDR_LSB.
  - Error if PADDR[ADDR_LSB-1:0] != 0 or index >= NUM_REGS.
- Write on completion, no error: the register is updated at the completing edge and reg_q reflects it the cycle after.
- Write on completion, error: no register changes and PSLVERR=1.
- Read: PRDATA = register[index] whenever PREADY=1, PWRITE=0 and there is no error. PRDATA is 0 in every other cycle, including error reads.
- PADDR, PWRITE and PWDATA are sampled in the completing cycle. Their stability through the transfer is the requester's obligation and is not checked.
- PENABLE=1 while in IDLE is ignored: no transfer starts.

## Timing
- WAIT_STATES=0:
  - PREADY is high in the first access cycle.
  - Each transfer takes 2 cycles, setup plus access.
- WAIT_STATES=N: PREADY is high in access cycle N+1, for a total of N+2 cycles.
- PREADY, PSLVERR and PRDATA are combinational from state, wait_cnt and the sampled APB inputs. There is no PCLK-to-output register stage.
- Back-to-back transfers: a new setup phase in the cycle immediately after completion is accepted from IDLE, with no idle cycle lost.
- Read-after-write to the same register in the next transfer returns the new value.
- Reset asserted mid-transfer:
  - Outputs clear immediately, asynchronously.
  - A write in progress is discarded.
  - After deassertion the block is in IDLE.

## Configuration
- APB_REGFILE_PSTRB_EN defined:
  - The PSTRB port exists.
  - A write updates only the byte lanes whose strobe is set; the other lanes keep their old value.
  - A write with PSTRB=0 completes normally with no change.
  - PSTRB is ignored on reads.
- APB_REGFILE_PSTRB_EN undefined:
  - There is no PSTRB port.
  - Every write updates the full word.

## Structure
- Package apb_regfile_pkg holds:
  - state_e (IDLE, ACCESS).
  - the WAIT_CNT_WIDTH=4 constant.
  - the function addr_lsb(data_width).
- Sub-module apb_access_fsm contains the state register, wait counter and PREADY generation. It is parametrised by WAIT_STATES.
- The top level holds decode, the register array, the strobe merge and the read mux.

## Test plan
- Reset, then a write to 0x04 with 0xDEADBEEF and WAIT_STATES=0 -> PREADY=1 in the 2nd cycle, PSLVERR=0, reg_q[63:32]=0xDEADBEEF the cycle after.
- WAIT_STATES=3, read of 0x04 -> PREADY low for 3 access cycles and high in the 4th, PRDATA=0xDEADBEEF only in that cycle.
- Write to 0x10 (index 4, NUM_REGS=4) and write to 0x02 (misaligned) -> PSLVERR=1 with PREADY, reg_q unchanged, error read gives PRDATA=0.
- Back-to-back write 0x0 = 0x11111111 then read 0x0 with no idle cycle -> read returns 0x11111111.
- With APB_REGFILE_PSTRB_EN, write 0xAABBCCDD with PSTRB=4'b0101 over 0x0 = 0x11111111 -> register reads 0x11BB11DD.
- Assert PRESETn low in the middle of a wait state (WAIT_STATES=3) of a write -> PREADY=0 and PRDATA=0 immediately, register stays 0, next transfer after release behaves normally.
